// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch core.
//   state_e      : FSM state encoding (2 bits)
//   *_MAX        : highest legal value of each fixed-limit BCD digit
//   bcd_next     : single-digit BCD increment with wrap at a given limit
package stopwatch_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2
   } state_e;

   localparam logic [3:0] TENTHS_MAX   = 4'd9;
   localparam logic [3:0] SEC_ONES_MAX = 4'd9;
   localparam logic [3:0] SEC_TENS_MAX = 4'd5;

   // Next value of one BCD digit: wraps to 0 once it has reached max.
   function automatic logic [3:0] bcd_next(input logic [3:0] d, input logic [3:0] max);
      return (d == max) ? 4'd0 : d + 4'd1;
   endfunction

endpackage

// File: rtl/sync_rise_det.sv
// Input conditioner: multi-flop synchroniser followed by a delay flop and a
// rising-edge detector. Produces a one-cycle pulse per rising edge of din;
// a level held high yields exactly one pulse.
//   clk    : system clock
//   rst_n  : asynchronous active-low reset, clears every flop
//   din    : asynchronous level input
//   rise   : one-cycle pulse, high in the cycle after the synchronised edge
module sync_rise_det #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic rise
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   dly_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
         dly_q  <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], din};
         dly_q  <= sync_q[SYNC_STAGES-1];
      end
   end

   assign rise = sync_q[SYNC_STAGES-1] & ~dly_q;

endmodule

// File: rtl/stopwatch_core.sv
// Tenths/seconds/minutes stopwatch running in the system clock domain.
// clk_10Hz is never used as a clock: it is synchronised and edge-detected
// into a one-cycle tick, as are the two debounced buttons.
//   clk            : 100 MHz system clock
//   rst_n          : asynchronous active-low reset
//   clk_10Hz       : 10 Hz square wave, asynchronous
//   btn_start_stop : rising edge toggles run/pause (starts from idle)
//   btn_clear      : rising edge zeroes the count and stops the watch
//   tenths, sec_ones, sec_tens, min_ones : BCD display digits
//   running        : high while in RUN
//   wrap           : one-cycle pulse on MIN_MAX:59.9 -> 0:00.0
module stopwatch_core
   import stopwatch_pkg::*;
#(
   parameter int unsigned SYNC_STAGES = 2,
   parameter int unsigned MIN_MAX     = 9
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clk_10Hz,
   input  logic       btn_start_stop,
   input  logic       btn_clear,
   output logic [3:0] tenths,
   output logic [3:0] sec_ones,
   output logic [3:0] sec_tens,
   output logic [3:0] min_ones,
   output logic       running,
   output logic       wrap
);

   localparam logic [3:0] MIN_LIM = 4'(MIN_MAX);

   logic tick_p;
   logic ss_p;
   logic clear_p;

   state_e     state_q, state_d;
   logic [3:0] tenths_q, tenths_d;
   logic [3:0] sec_ones_q, sec_ones_d;
   logic [3:0] sec_tens_q, sec_tens_d;
   logic [3:0] min_ones_q, min_ones_d;
   logic       running_q, running_d;
   logic       wrap_q, wrap_d;

   // ------------------------------------------------------------------
   // Input conditioning
   // ------------------------------------------------------------------
   sync_rise_det #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync_tick (
      .clk  (clk),
      .rst_n(rst_n),
      .din  (clk_10Hz),
      .rise (tick_p)
   );

   sync_rise_det #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync_ss (
      .clk  (clk),
      .rst_n(rst_n),
      .din  (btn_start_stop),
      .rise (ss_p)
   );

   sync_rise_det #(
      .SYNC_STAGES(SYNC_STAGES)
   ) u_sync_clear (
      .clk  (clk),
      .rst_n(rst_n),
      .din  (btn_clear),
      .rise (clear_p)
   );

   // ------------------------------------------------------------------
   // Next state: clear beats start/stop, which beats (and swallows) a tick
   // ------------------------------------------------------------------
   always_comb begin
      state_d    = state_q;
      tenths_d   = tenths_q;
      sec_ones_d = sec_ones_q;
      sec_tens_d = sec_tens_q;
      min_ones_d = min_ones_q;
      wrap_d     = 1'b0;

      if (clear_p) begin
         state_d    = ST_IDLE;
         tenths_d   = 4'd0;
         sec_ones_d = 4'd0;
         sec_tens_d = 4'd0;
         min_ones_d = 4'd0;
      end else if (ss_p) begin
         case (state_q)
            ST_RUN:  state_d = ST_PAUSE;
            default: state_d = ST_RUN;
         endcase
      end else if (tick_p && (state_q == ST_RUN)) begin
         // Whole cascade resolved combinationally so every digit moves on one edge.
         tenths_d = bcd_next(tenths_q, TENTHS_MAX);
         if (tenths_q == TENTHS_MAX) begin
            sec_ones_d = bcd_next(sec_ones_q, SEC_ONES_MAX);
            if (sec_ones_q == SEC_ONES_MAX) begin
               sec_tens_d = bcd_next(sec_tens_q, SEC_TENS_MAX);
               if (sec_tens_q == SEC_TENS_MAX) begin
                  min_ones_d = bcd_next(min_ones_q, MIN_LIM);
                  if (min_ones_q == MIN_LIM) begin
                     wrap_d = 1'b1;
                  end
               end
            end
         end
      end

      running_d = (state_d == ST_RUN);
   end

   // ------------------------------------------------------------------
   // State and output registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         tenths_q   <= 4'd0;
         sec_ones_q <= 4'd0;
         sec_tens_q <= 4'd0;
         min_ones_q <= 4'd0;
         running_q  <= 1'b0;
         wrap_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         tenths_q   <= tenths_d;
         sec_ones_q <= sec_ones_d;
         sec_tens_q <= sec_tens_d;
         min_ones_q <= min_ones_d;
         running_q  <= running_d;
         wrap_q     <= wrap_d;
      end
   end

   assign tenths   = tenths_q;
   assign sec_ones = sec_ones_q;
   assign sec_tens = sec_tens_q;
   assign min_ones = min_ones_q;
   assign running  = running_q;
   assign wrap     = wrap_q;

   // ------------------------------------------------------------------
   // Digit range checks
   // ------------------------------------------------------------------
   a_tenths_bcd: assert property (@(posedge clk) disable iff (!rst_n)
      tenths_q <= TENTHS_MAX);
   a_sec_ones_bcd: assert property (@(posedge clk) disable iff (!rst_n)
      sec_ones_q <= SEC_ONES_MAX);
   a_sec_tens_bcd: assert property (@(posedge clk) disable iff (!rst_n)
      sec_tens_q <= SEC_TENS_MAX);
   a_min_ones_bcd: assert property (@(posedge clk) disable iff (!rst_n)
      min_ones_q <= MIN_LIM);
   a_running_match: assert property (@(posedge clk) disable iff (!rst_n)
      running_q == (state_q == ST_RUN));

endmodule
